imul_req_arbiter: RTL and testbench
===================================

# imul_req_arbiter

Two-port arbiter that shares one multi-cycle integer multiplier between two independent val/rdy requesters. It latches the winning request, issues it to the multiplier, and steers the 32-bit response back to the requester that owns it. One transaction is outstanding at a time. The block sits between requester-side message interfaces and the multiplier's `in_*`/`out_*` ports.

## Interface
- `p_msg_nbits`, 65: request message width (func, a, b), passed through unmodified.
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `req0_val` / `req1_val`  in  1: requester request valid.
- `req0_rdy` / `req1_rdy`  out  1: requester request ready.
- `req0_msg` / `req1_msg`  in  p_msg_nbits: requester request message.
- `resp0_val` / `resp1_val`  out  1: response valid to requester.
- `resp0_rdy` / `resp1_rdy`  in  1: requester response ready.
- `resp_msg`  out  32: response data, shared by both ports; qualified by `respN_val`.
- `mul_req_val`  out  1: request valid to the multiplier.
- `mul_req_rdy`  in  1: multiplier request ready.
- `mul_req_msg`  out  p_msg_nbits: latched request to the multiplier.
- `mul_resp_val`  in  1: multiplier response valid.
- `mul_resp_rdy`  out  1: response ready to the multiplier.
- `mul_resp_msg`  in  32: multiplier result.
- `owner`  out  1: port index of the current or last grant (debug/trace).

## Operation
- FSM with states IDLE(0), ISSUE(1), WAIT(2), encoded in 2 bits.
- **IDLE:**
  - `reqN_rdy` = 1 only for the arbitration winner; the other port's `rdy` = 0.
  - No winner when neither `reqN_val` is high; both `rdy` = 0.
  - On a winner handshake: latch `reqN_msg` into the request register, set `owner` = N, go to ISSUE.
- **ISSUE:**
  - `mul_req_val` = 1, `mul_req_msg` = latched request.
  - When `mul_req_rdy` = 1, go to WAIT.
- **WAIT:**
  - `resp{owner}_val` = `mul_resp_val`; `resp_msg` = `mul_resp_msg`.
  - `mul_resp_rdy` = `resp{owner}_rdy`. The non-owner's `resp_val` = 0.
  - When `mul_resp_val` and `resp{owner}_rdy` are both high, go to IDLE.
- **Arbitration:**
  - Only one requester valid: it wins.
  - Both valid: the winner is chosen per the Configuration section.
  - The priority pointer updates only on an accepted request, never on a mere `val`.
- In ISSUE and WAIT, both `reqN_rdy` = 0. Requests are held off, never dropped.
- Message contents are never altered. `resp_msg` is don't-care outside WAIT.
- Assertion: outside reset, `mul_resp_val` = 1 in IDLE or ISSUE is an error (X/unsolicited-response check).

## Timing
- **Reset** (synchronous):
  - State = IDLE, `owner` = 0, priority pointer = 0.
  - Every `*_val` and `*_rdy` output = 0 during the reset cycle.
  - A reset mid-transaction abandons it; the multiplier is expected to be reset by the same signal.
- **Request path:**
  - Request accepted on cycle t (IDLE) → `mul_req_val` high from t+1.
  - Minimum 1 cycle of added latency on the request path.
- **Response path:** combinational, 0 added latency. `respN_val` follows `mul_resp_val` in the same cycle.
- **Back-to-back transactions:**
  - A response handshake on cycle t → IDLE on t+1, when a new request can be accepted.
  - Minimum occupancy is therefore 3 cycles plus multiplier latency.
- **Backpressure:**
  - `mul_req_rdy` low holds ISSUE indefinitely with the message stable.
  - `resp{owner}_rdy` low holds WAIT with `mul_resp_rdy` low.
- `reqN_rdy` depends combinationally on `reqN_val` of both ports. It never depends on the multiplier ports.

## Configuration
- Macro `IMUL_REQ_ARBITER_ROUND_ROBIN_EN`.
- **Defined:** round-robin.
  - The priority pointer names the favoured port.
  - After a grant to port N, the pointer becomes !N.
  - Both valid → the pointer's port wins.
- **Undefined:** fixed priority, port 0 always wins when both are valid.
  - Pointer logic is removed; `owner` still records the grant.

## Test plan
- **Single request:** `req0` with a=3, b=7, multiplier returns 21.
  - `resp0_val` with `resp_msg` = 0x15.
  - `resp1_val` never asserted.
  - `req0_rdy` high only in the cycle after reset deasserts and the state is IDLE.
- **Both ports valid continuously** (req0 a=2,b=5; req1 a=4,b=4):
  - RR build: grants alternate 0,1,0,1, responses 10,16,10,16.
  - Fixed build: port 0 is granted every time and port 1 starves.
- **`mul_req_rdy` held low 5 cycles in ISSUE:**
  - `mul_req_val` stays 1 with a constant message.
  - Both `reqN_rdy` = 0 throughout; exactly one request is issued.
- **`resp1_rdy` low 4 cycles while `mul_resp_val` = 1** (result 0xFFFFFFFE from a=0xFFFFFFFF, b=2):
  - `mul_resp_rdy` = 0 for those cycles.
  - Handshake on the first cycle `resp1_rdy` = 1; IDLE on the next cycle.
- **Reset asserted in WAIT:**
  - Next cycle: state IDLE, all val/rdy outputs 0, pointer 0.
  - A subsequent `req1` transaction completes normally.
- **Unsolicited `mul_resp_val` in IDLE:** the assertion fires.

Source files
------------

// File: rtl/imul_req_arbiter.sv
// rtl/imul_req_arbiter.sv - two-port val/rdy arbiter sharing one multi-cycle integer multiplier
// Optional round-robin arbitration via IMUL_REQ_ARBITER_ROUND_ROBIN_EN (fixed port-0 priority otherwise).
module imul_req_arbiter #(
  parameter int p_msg_nbits = 65
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   req0_val,
  output logic                   req0_rdy,
  input  logic [p_msg_nbits-1:0] req0_msg,
  input  logic                   req1_val,
  output logic                   req1_rdy,
  input  logic [p_msg_nbits-1:0] req1_msg,

  output logic                   resp0_val,
  input  logic                   resp0_rdy,
  output logic                   resp1_val,
  input  logic                   resp1_rdy,
  output logic [31:0]            resp_msg,

  output logic                   mul_req_val,
  input  logic                   mul_req_rdy,
  output logic [p_msg_nbits-1:0] mul_req_msg,

  input  logic                   mul_resp_val,
  output logic                   mul_resp_rdy,
  input  logic [31:0]            mul_resp_msg,

  output logic                   owner
);

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_ISSUE = 2'd1;
  localparam logic [1:0] STATE_WAIT  = 2'd2;

  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [p_msg_nbits-1:0] req_reg;
  logic                   winner;
  logic                   grant;
  logic                   in_wait;

`ifdef IMUL_REQ_ARBITER_ROUND_ROBIN_EN
  logic prio;

  // The pointer only matters on a tie; a lone requester always wins.
  assign winner = (req0_val && req1_val) ? prio : req1_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (grant) begin
      prio <= ~winner;
    end
  end
`else
  assign winner = ~req0_val;
`endif

  // Outputs are gated by reset so every val/rdy is low in the reset cycle itself.
  assign grant    = !reset && (state == STATE_IDLE) && (req0_val || req1_val);
  assign req0_rdy = grant && !winner;
  assign req1_rdy = grant && winner;

  assign mul_req_val = !reset && (state == STATE_ISSUE);
  assign mul_req_msg = req_reg;

  assign in_wait      = !reset && (state == STATE_WAIT);
  assign resp0_val    = in_wait && !owner && mul_resp_val;
  assign resp1_val    = in_wait && owner && mul_resp_val;
  assign mul_resp_rdy = in_wait && (owner ? resp1_rdy : resp0_rdy);
  assign resp_msg     = mul_resp_msg;

  always_comb begin
    state_next = state;
    case (state)
      STATE_IDLE:  if (grant) state_next = STATE_ISSUE;
      STATE_ISSUE: if (mul_req_rdy) state_next = STATE_WAIT;
      STATE_WAIT:  if (mul_resp_val && mul_resp_rdy) state_next = STATE_IDLE;
      default:     state_next = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= STATE_IDLE;
      owner   <= 1'b0;
      req_reg <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        req_reg <= winner ? req1_msg : req0_msg;
        owner   <= winner;
      end
    end
  end

  // A response can only be legitimate while a request is outstanding.
  unsolicited_resp: assert property (@(posedge clk) disable iff (reset)
    !(mul_resp_val && (state != STATE_WAIT)));

endmodule

// File: tb/tb_imul_req_arbiter.sv
// tb/tb_imul_req_arbiter.sv - self-checking bench for imul_req_arbiter
// Transaction-level reference model, behavioural multiplier, directed and random stimulus.
`timescale 1ns/100ps
module tb_imul_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_val, req1_val, req0_rdy, req1_rdy;
  logic [64:0] req0_msg, req1_msg;
  logic        resp0_val, resp1_val, resp0_rdy, resp1_rdy;
  logic [31:0] resp_msg;
  logic        mul_req_val, mul_req_rdy;
  logic [64:0] mul_req_msg;
  logic        mul_resp_val, mul_resp_rdy;
  logic [31:0] mul_resp_msg;
  logic        owner;

  always #10 clk = ~clk;

  imul_req_arbiter #(.p_msg_nbits(65)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .resp_msg(resp_msg),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
    .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg),
    .owner(owner)
  );

  int errors = 0;
  int checks = 0;

  // reference model: one held transaction, whether it was handed on, who owns it
  bit          m_busy, m_issued, m_owner, m_fav;
  logic [64:0] m_msg;

  // behavioural multiplier
  bit          mp_pending;
  int          mp_cnt;
  int          mul_lat = 0;
  logic [31:0] mp_res;

  // negedge observations
  bit          s_issue, s_resp_hs;
  logic [64:0] s_req_msg;
  bit          grant_q[$];
  bit          resp_port_q[$];
  logic [31:0] resp_data_q[$];
  int          issue_cnt, req_stall_cnt, resp_stall_cnt, resp1_seen;

  typedef struct {
    bit rst, v0, v1, r0, r1;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [64:0] mk(input logic [31:0] a, input logic [31:0] b);
    return {1'b0, a, b};
  endfunction

  function automatic logic [31:0] prod(input logic [64:0] m);
    logic [31:0] a, b;
    a = m[63:32];
    b = m[31:0];
    return a * b;
  endfunction

  function automatic bit pick();
    if (req0_val && req1_val) begin
`ifdef IMUL_REQ_ARBITER_ROUND_ROBIN_EN
      return m_fav;
`else
      return 1'b0;
`endif
    end
    return req1_val;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit e_r0, e_r1, e_mrv, e_rv0, e_rv1, e_mrr, w;
    e_r0 = 0; e_r1 = 0; e_mrv = 0; e_rv0 = 0; e_rv1 = 0; e_mrr = 0;
    if (!reset) begin
      if (!m_busy) begin
        if (req0_val || req1_val) begin
          w = pick();
          e_r0 = !w;
          e_r1 = w;
        end
      end else if (!m_issued) begin
        e_mrv = 1;
      end else begin
        e_rv0 = !m_owner && mul_resp_val;
        e_rv1 = m_owner && mul_resp_val;
        e_mrr = m_owner ? resp1_rdy : resp0_rdy;
      end
    end
    chk("req0_rdy", 64'(req0_rdy), 64'(e_r0));
    chk("req1_rdy", 64'(req1_rdy), 64'(e_r1));
    chk("mul_req_val", 64'(mul_req_val), 64'(e_mrv));
    chk("resp0_val", 64'(resp0_val), 64'(e_rv0));
    chk("resp1_val", 64'(resp1_val), 64'(e_rv1));
    chk("mul_resp_rdy", 64'(mul_resp_rdy), 64'(e_mrr));
    if (!reset) chk("owner", 64'(owner), 64'(m_owner));
    if (!reset && m_busy && !m_issued) chk("mul_req_msg", 64'(mul_req_msg), 64'(m_msg));
    if (e_rv0 || e_rv1) chk("resp_msg", 64'(resp_msg), 64'(prod(m_msg)));
  endtask

  task automatic observe();
    s_issue   = mul_req_val && mul_req_rdy;
    s_req_msg = mul_req_msg;
    s_resp_hs = mul_resp_val && mul_resp_rdy;
    if (!reset && req0_val && req0_rdy) grant_q.push_back(1'b0);
    if (!reset && req1_val && req1_rdy) grant_q.push_back(1'b1);
    if (resp0_val && resp0_rdy) begin resp_port_q.push_back(1'b0); resp_data_q.push_back(resp_msg); end
    if (resp1_val && resp1_rdy) begin resp_port_q.push_back(1'b1); resp_data_q.push_back(resp_msg); end
    if (s_issue) issue_cnt++;
    if (mul_req_val && !mul_req_rdy) req_stall_cnt++;
    if (mul_resp_val && !mul_resp_rdy) resp_stall_cnt++;
    if (resp1_val) resp1_seen++;
  endtask

  task automatic model_update();
    bit w;
    if (reset) begin
      m_busy = 0; m_issued = 0; m_owner = 0; m_fav = 0;
    end else if (!m_busy) begin
      if (req0_val || req1_val) begin
        w = pick();
        m_busy = 1; m_issued = 0; m_owner = w;
        m_msg = w ? req1_msg : req0_msg;
        m_fav = !w;
      end
    end else if (!m_issued) begin
      if (mul_req_rdy) m_issued = 1;
    end else if (mul_resp_val && (m_owner ? resp1_rdy : resp0_rdy)) begin
      m_busy = 0;
    end
  endtask

  task automatic env_update();
    if (reset) begin
      mp_pending = 0;
    end else if (mp_pending) begin
      if (mp_cnt == 0) begin
        if (s_resp_hs) mp_pending = 0;
      end else begin
        mp_cnt--;
      end
    end else if (s_issue) begin
      mp_pending = 1;
      mp_cnt = mul_lat;
      mp_res = prod(s_req_msg);
    end
  endtask

  task automatic tick();
    mul_resp_val = mp_pending && (mp_cnt == 0);
    mul_resp_msg = mp_pending ? mp_res : 32'($urandom);
    @(negedge clk);
    check_outputs();
    observe();
    @(posedge clk);
    model_update();
    env_update();
    #1;
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (m_busy) begin
      errors++;
      $display("FAIL %s: timeout, transaction still open after %0d cycles", name, budget);
    end
  endtask

  task automatic clear_obs();
    grant_q.delete(); resp_port_q.delete(); resp_data_q.delete();
    issue_cnt = 0; req_stall_cnt = 0; resp_stall_cnt = 0; resp1_seen = 0;
  endtask

  task automatic pulse_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    int n;
    reset = 1; req0_val = 0; req1_val = 0; req0_msg = '0; req1_msg = '0;
    resp0_rdy = 0; resp1_rdy = 0; mul_req_rdy = 0; mul_resp_val = 0; mul_resp_msg = '0;
    m_busy = 0; m_issued = 0; m_owner = 0; m_fav = 0; m_msg = '0;
    mp_pending = 0; mp_cnt = 0; mp_res = '0;
    clear_obs();
    tick();
    tick();
    reset = 0;

    // combinational arbitration from a fresh IDLE (pointer at 0)
    vecs[0] = '{0, 0, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 1, 0};
    vecs[2] = '{0, 0, 1, 0, 1};
    vecs[3] = '{0, 1, 1, 1, 0};
    vecs[4] = '{1, 1, 1, 0, 0};
    vecs[5] = '{1, 0, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      reset = vecs[i].rst; req0_val = vecs[i].v0; req1_val = vecs[i].v1;
      #1;
      chk($sformatf("vec%0d_req0_rdy", i), 64'(req0_rdy), 64'(vecs[i].r0));
      chk($sformatf("vec%0d_req1_rdy", i), 64'(req1_rdy), 64'(vecs[i].r1));
    end
    reset = 0; req0_val = 0; req1_val = 0;

    // single request: 3*7
    clear_obs();
    mul_lat = 2; mul_req_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
    req0_val = 1; req0_msg = mk(32'd3, 32'd7);
    tick();
    req0_val = 0;
    run_until_idle("single", 20);
    chk("single_resp_count", 64'(resp_data_q.size()), 64'd1);
    if (resp_data_q.size() == 1) begin
      chk("single_resp_port", 64'(resp_port_q[0]), 64'd0);
      chk("single_resp_data", 64'(resp_data_q[0]), 64'h15);
    end
    chk("single_resp1_never", 64'(resp1_seen), 64'd0);

    // both ports valid continuously
    pulse_reset();
    clear_obs();
    mul_lat = 1;
    req0_val = 1; req0_msg = mk(32'd2, 32'd5);
    req1_val = 1; req1_msg = mk(32'd4, 32'd4);
    n = 0;
    while (grant_q.size() < 4 && n < 60) begin tick(); n++; end
    req0_val = 0; req1_val = 0;
    run_until_idle("both", 20);
    chk("both_grant_count", 64'(grant_q.size()), 64'd4);
    chk("both_resp_count", 64'(resp_data_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      bit ep;
`ifdef IMUL_REQ_ARBITER_ROUND_ROBIN_EN
      ep = i[0];
`else
      ep = 1'b0;
`endif
      if (i < grant_q.size()) chk($sformatf("both_grant%0d", i), 64'(grant_q[i]), 64'(ep));
      if (i < resp_data_q.size())
        chk($sformatf("both_resp%0d", i), 64'(resp_data_q[i]), ep ? 64'd16 : 64'd10);
    end

    // multiplier request backpressure for 5 cycles
    clear_obs();
    mul_req_rdy = 0;
    req1_val = 1; req1_msg = mk(32'd9, 32'd11);
    tick();
    req0_val = 1; req0_msg = mk(32'd1, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    mul_req_rdy = 1; req0_val = 0; req1_val = 0;
    run_until_idle("issue_stall", 20);
    chk("issue_stall_cycles", 64'(req_stall_cnt), 64'd5);
    chk("issue_stall_issues", 64'(issue_cnt), 64'd1);
    if (resp_data_q.size() == 1) chk("issue_stall_resp", 64'(resp_data_q[0]), 64'd99);
    else chk("issue_stall_resp_count", 64'(resp_data_q.size()), 64'd1);

    // response backpressure on port 1 for 4 cycles
    clear_obs();
    mul_lat = 0; resp1_rdy = 0;
    req1_val = 1; req1_msg = mk(32'hFFFF_FFFF, 32'd2);
    tick();
    req1_val = 0;
    n = 0;
    while (!(mp_pending && mp_cnt == 0) && n < 10) begin tick(); n++; end
    for (int i = 0; i < 4; i++) tick();
    resp1_rdy = 1;
    tick();
    chk("resp_stall_done", 64'(m_busy), 64'd0);
    req0_val = 1; req0_msg = mk(32'd6, 32'd6);
    tick();
    req0_val = 0;
    run_until_idle("resp_stall", 20);
    chk("resp_stall_cycles", 64'(resp_stall_cnt), 64'd4);
    if (resp_data_q.size() >= 1) chk("resp_stall_data", 64'(resp_data_q[0]), 64'hFFFF_FFFE);
    else chk("resp_stall_resp_count", 64'(resp_data_q.size()), 64'd2);

    // reset while waiting on the multiplier
    clear_obs();
    mul_lat = 3;
    req0_val = 1; req0_msg = mk(32'd5, 32'd6);
    tick();
    req0_val = 0;
    tick();
    chk("rst_wait_reached", 64'(m_issued), 64'd1);
    pulse_reset();
    req0_val = 1; req1_val = 1;
    #1;
    chk("rst_ptr_req0_rdy", 64'(req0_rdy), 64'd1);
    chk("rst_ptr_req1_rdy", 64'(req1_rdy), 64'd0);
    req0_val = 0; req1_msg = mk(32'd7, 32'd8);
    tick();
    req1_val = 0;
    run_until_idle("after_reset", 20);
    chk("after_reset_count", 64'(resp_data_q.size()), 64'd1);
    if (resp_data_q.size() == 1) begin
      chk("after_reset_port", 64'(resp_port_q[0]), 64'd1);
      chk("after_reset_data", 64'(resp_data_q[0]), 64'd56);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      req0_val    = $urandom_range(0, 1) == 1;
      req1_val    = $urandom_range(0, 1) == 1;
      req0_msg    = {1'($urandom), 32'($urandom), 32'($urandom)};
      req1_msg    = {1'($urandom), 32'($urandom), 32'($urandom)};
      mul_req_rdy = $urandom_range(0, 9) < 7;
      resp0_rdy   = $urandom_range(0, 9) < 7;
      resp1_rdy   = $urandom_range(0, 9) < 7;
      mul_lat     = $urandom_range(0, 3);
      tick();
    end
    reset = 0; req0_val = 0; req1_val = 0;
    mul_req_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
    run_until_idle("random_drain", 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
